// File: rtl/mult_div_ctrl.sv
// Iterative signed multiply/divide sequencer for the HI/LO result path.
// Booth radix-2 multiply or restoring divide, 32 iterations, then a FIX cycle that registers hi/lo.
module mult_div_ctrl (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic        i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_div_zero,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MULT = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_FIX  = 2'd3;

   logic [1:0]  r_state;
   logic [5:0]  r_cnt;
   logic        r_op;
   logic        r_busy;
   logic        r_done;
   logic        r_div_zero;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic [64:0] r_acc;
   logic [32:0] r_mcand;
   logic        r_booth;

   logic [32:0] r_rem;
   logic [31:0] r_quo;
   logic [32:0] r_divisor;
   logic        r_q_neg;
   logic        r_r_neg;

   logic [32:0] w_upper;
   logic [64:0] w_acc_next;
   logic [33:0] w_div_shift;
   logic [33:0] w_div_diff;
   logic [32:0] w_rem_next;
   logic [31:0] w_quo_next;

   function automatic logic [31:0] f_neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   function automatic logic [31:0] f_abs32(input logic [31:0] v);
      if (v[31]) begin
         return f_neg32(v);
      end else begin
         return v;
      end
   endfunction

   // Booth step: {q0, q-1} selects add/subtract of the multiplicand into the upper 33 bits, then arithmetic shift.
   always_comb begin
      w_upper = r_acc[64:32];
      case ({r_acc[0], r_booth})
         2'b01:   w_upper = r_acc[64:32] + r_mcand;
         2'b10:   w_upper = r_acc[64:32] - r_mcand;
         default: w_upper = r_acc[64:32];
      endcase
      w_acc_next = {w_upper[32], w_upper, r_acc[31:1]};
   end

   // Restoring step: bit 33 of the trial difference is its sign.
   always_comb begin
      w_div_shift = {r_rem, r_quo[31]};
      w_div_diff  = w_div_shift - {1'b0, r_divisor};
      if (!w_div_diff[33]) begin
         w_rem_next = w_div_diff[32:0];
         w_quo_next = {r_quo[30:0], 1'b1};
      end else begin
         w_rem_next = w_div_shift[32:0];
         w_quo_next = {r_quo[30:0], 1'b0};
      end
   end

   // Sequencer FSM and result registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_cnt      <= 6'd0;
         r_op       <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
         r_acc      <= 65'd0;
         r_mcand    <= 33'd0;
         r_booth    <= 1'b0;
         r_rem      <= 33'd0;
         r_quo      <= 32'd0;
         r_divisor  <= 33'd0;
         r_q_neg    <= 1'b0;
         r_r_neg    <= 1'b0;
      end else begin
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (!i_op) begin
                     r_op    <= 1'b0;
                     r_mcand <= {i_a[31], i_a};
                     r_acc   <= {33'd0, i_b};
                     r_booth <= 1'b0;
                     r_cnt   <= 6'd0;
                     r_busy  <= 1'b1;
                     r_state <= S_MULT;
                  end else if (i_b != 32'd0) begin
                     r_op      <= 1'b1;
                     r_divisor <= {1'b0, f_abs32(i_b)};
                     r_quo     <= f_abs32(i_a);
                     r_rem     <= 33'd0;
                     r_r_neg   <= i_a[31];
                     r_q_neg   <= i_a[31] ^ i_b[31];
                     r_cnt     <= 6'd0;
                     r_busy    <= 1'b1;
                     r_state   <= S_DIV;
                  end else begin
                     // Divide-by-zero completes immediately; hi/lo keep their previous result.
                     r_done     <= 1'b1;
                     r_div_zero <= 1'b1;
                  end
               end
            end
            S_MULT: begin
               r_acc   <= w_acc_next;
               r_booth <= r_acc[0];
               r_cnt   <= r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  r_state <= S_FIX;
               end
            end
            S_DIV: begin
               r_rem <= w_rem_next;
               r_quo <= w_quo_next;
               r_cnt <= r_cnt + 6'd1;
               if (r_cnt == 6'd31) begin
                  r_state <= S_FIX;
               end
            end
            S_FIX: begin
               if (!r_op) begin
                  r_hi <= r_acc[63:32];
                  r_lo <= r_acc[31:0];
               end else begin
                  r_lo <= r_q_neg ? f_neg32(r_quo) : r_quo;
                  r_hi <= r_r_neg ? f_neg32(r_rem[31:0]) : r_rem[31:0];
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_cnt   <= 6'd0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_busy     = r_busy;
   assign o_done     = r_done;
   assign o_div_zero = r_div_zero;
   assign o_hi       = r_hi;
   assign o_lo       = r_lo;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Self-checking bench for mult_div_ctrl: directed cases plus random operations against an arithmetic model.
module tb_mult_div_ctrl;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks;
   int n_fail;

   mult_div_ctrl dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_start    (start),
      .i_op       (op),
      .i_a        (a),
      .i_b        (b),
      .o_busy     (busy),
      .o_done     (done),
      .o_div_zero (div_zero),
      .o_hi       (hi),
      .o_lo       (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Reference: signed 64-bit product, or C-style truncating divide with remainder taking the dividend's sign.
   function automatic logic [63:0] model(input logic mop, input logic [31:0] ma, input logic [31:0] mb);
      longint sa;
      longint sb;
      longint p;
      longint q;
      longint r;
      logic [63:0] pv;
      logic [63:0] qv;
      logic [63:0] rv;
      sa = $signed(ma);
      sb = $signed(mb);
      if (!mop) begin
         p  = sa * sb;
         pv = p;
         return pv;
      end else begin
         q  = sa / sb;
         r  = sa % sb;
         qv = q;
         rv = r;
         return {rv[31:0], qv[31:0]};
      end
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return $urandom_range(0, 20);
         3:       return 32'd0 - $urandom_range(1, 20);
         default: return $urandom();
      endcase
   endfunction

   // Called at a negedge; E0 is the next posedge. Returns at the negedge after E0.
   task automatic issue(input logic iop, input logic [31:0] ia, input logic [31:0] ib);
      start = 1'b1;
      op    = iop;
      a     = ia;
      b     = ib;
      @(negedge clk);
      start = 1'b0;
      a     = $urandom();
      b     = $urandom();
   endtask

   // cyc0 is the negedge count already elapsed since E0; returns at the done-cycle negedge.
   task automatic wait_done(input string tag, input logic [31:0] eh, input logic [31:0] el, input int cyc0);
      int  cyc;
      logic busy_ok;
      cyc     = cyc0;
      busy_ok = 1'b1;
      while (done !== 1'b1 && cyc < 60) begin
         if (busy !== 1'b1) busy_ok = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check1({tag, " busy_during_op"}, busy_ok, 1'b1);
      check32({tag, " latency"}, cyc, 32'd33);
      check1({tag, " done"}, done, 1'b1);
      check1({tag, " busy_in_done"}, busy, 1'b0);
      check1({tag, " div_zero"}, div_zero, 1'b0);
      check32({tag, " hi"}, hi, eh);
      check32({tag, " lo"}, lo, el);
   endtask

   task automatic run_op(input string tag, input logic iop, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] eh, input logic [31:0] el);
      issue(iop, ia, ib);
      wait_done(tag, eh, el, 0);
      @(negedge clk);
      check1({tag, " done_single"}, done, 1'b0);
   endtask

   initial begin
      logic [63:0] m;
      logic        rop;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        saw_done;
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      start = 1'b0;
      op    = 1'b0;
      a     = 32'd0;
      b     = 32'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check1("reset busy", busy, 1'b0);
      check1("reset done", done, 1'b0);
      check1("reset div_zero", div_zero, 1'b0);
      check32("reset hi", hi, 32'd0);
      check32("reset lo", lo, 32'd0);

      run_op("mult 7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      run_op("mult min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
      run_op("mult -1*-1", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);
      run_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
      run_op("div 100/7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);

      // Abort an operation with reset partway through the iterations.
      issue(1'b0, 32'd5, 32'd9);
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check1("abort busy", busy, 1'b0);
      check1("abort done", done, 1'b0);
      check32("abort hi", hi, 32'd0);
      check32("abort lo", lo, 32'd0);
      saw_done = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) saw_done = 1'b1;
      end
      check1("abort no_done", saw_done, 1'b0);

      // Preload hi/lo = 0x11/0x22, then divide by zero.
      run_op("preload", 1'b0, 32'h2AAA_AAAB, 32'h0000_0066, 32'h0000_0011, 32'h0000_0022);
      issue(1'b1, 32'd1234, 32'd0);
      check1("divz done", done, 1'b1);
      check1("divz flag", div_zero, 1'b1);
      check1("divz busy", busy, 1'b0);
      check32("divz hi", hi, 32'h0000_0011);
      check32("divz lo", lo, 32'h0000_0022);
      @(negedge clk);
      check1("divz done_single", done, 1'b0);
      check1("divz flag_single", div_zero, 1'b0);
      check1("divz busy_after", busy, 1'b0);

      // start held high (with changing operands) during a mult must not restart it.
      start = 1'b1;
      op    = 1'b0;
      a     = 32'd7;
      b     = 32'hFFFF_FFFD;
      @(negedge clk);
      for (int k = 0; k < 20; k++) begin
         op = 1'($urandom_range(0, 1));
         a  = $urandom();
         b  = $urandom();
         @(negedge clk);
      end
      start = 1'b0;
      wait_done("held start", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 20);
      // Back-to-back: issue a div in the done cycle.
      issue(1'b1, 32'd100, 32'hFFFF_FFF9);
      wait_done("back2back", 32'd2, 32'hFFFF_FFF2, 0);
      @(negedge clk);
      check1("back2back done_single", done, 1'b0);

      for (int i = 0; i < 14; i++) begin
         rop = 1'($urandom_range(0, 1));
         ra  = pick();
         rb  = pick();
         if (rop && rb == 32'd0) rb = 32'd3;
         m = model(rop, ra, rb);
         run_op(rop ? "rand div" : "rand mult", rop, ra, rb, m[63:32], m[31:0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Iterative signed multiply/divide sequencer that owns the HI/LO result path of the multicycle CPU. The main control FSM pulses `start` with the opcode class. The block runs a 32-iteration shift-add multiply (Booth radix-2) or a restoring divide on operands from registers A/B, then presents `hi`/`lo` with a one-cycle `done`. The control FSM waits on `busy`/`done` and then asserts HILOWrite, selecting this block's outputs through the HI/LO source muxes. Divide-by-zero is reported to the exception logic.

## Interface
- No parameters; datapath width is fixed at 32.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high. One clock; reset is synchronous and active-high.
- `start`  in  1  operation request, sampled only in IDLE.
- `op`  in  1  0 = mult (signed), 1 = div (signed); sampled with `start`.
- `a`  in  32  multiplicand / dividend (register A), sampled with `start`.
- `b`  in  32  multiplier / divisor (register B), sampled with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse; `hi`/`lo` are valid while it is high.
- `div_zero`  out  1  one-cycle pulse coincident with `done` when the divisor is 0.
- `hi`  out  32  mult: product[63:32]; div: remainder.
- `lo`  out  32  mult: product[31:0]; div: quotient.

## Operation
- States: IDLE, MULT, DIV, FIX.
- IDLE, `start`=0: hold all state.
- IDLE, `start`=1, `op`=0: latch operands, clear product accumulator and the Booth bit, counter=0, go to MULT.
- IDLE, `start`=1, `op`=1, `b`≠0:
  - latch |a| and |b|, the dividend sign and the quotient sign (sign(a) XOR sign(b)), counter=0, go to DIV.
- IDLE, `start`=1, `op`=1, `b`=0: stay in IDLE; `done`=1 and `div_zero`=1 next cycle; `hi`/`lo` unchanged.
- MULT: one Booth step per cycle.
  - Add or subtract the multiplicand into the upper 33 bits of the accumulator per {q0, q-1}.
  - Arithmetic-shift the accumulator right by 1; counter++.
  - After 32 steps go to FIX.
- DIV: one restoring step per cycle on magnitudes.
  - Shift {rem, quo} left by 1 and trial-subtract |b| from rem.
  - If the result is non-negative, keep it and set the quotient LSB; otherwise restore.
  - counter++; after 32 steps go to FIX.
- FIX:
  - mult: `hi`←acc[63:32], `lo`←acc[31:0].
  - div: `lo`←quo, negated if the quotient sign is 1; `hi`←rem, negated if the dividend sign is 1. Quotient truncates toward zero; remainder takes the dividend's sign.
  - Assert `done` next cycle and return to IDLE.
- Width rules:
  - The Booth accumulator is 65 bits so that the 0x80000000 operand is handled.
  - Divide uses 33-bit |a|/|b| magnitudes.
  - 0x80000000 / 0xFFFFFFFF gives `lo`=0x80000000, `hi`=0 (wraps, no flag).
- `start` while `busy` is ignored; the operands in flight are unaffected.
- `hi`/`lo` hold their last result until the next FIX or reset.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, counter=0.
- Reset mid-operation aborts on that edge: IDLE next cycle, no `done`, `hi`/`lo` forced to 0.
- Edge numbering: E0 is the edge that samples `start`=1 in IDLE.
  - `busy` is high from after E0 through the cycle after E32.
  - Iterations occur at E1..E32.
  - FIX registers `hi`/`lo` and `done`=1 at E33.
  - `done` is high for exactly the cycle between E33 and E34; `busy`=0 in that cycle.
  - Total latency is 33 cycles.
- Divide-by-zero latency is 1 cycle: `done`/`div_zero` are high after E0; `busy` never rises.
- Back-to-back: `start` high during the `done` cycle is accepted at E34 (the state is already IDLE).
- `done` and `div_zero` are never high for two consecutive cycles from one request.

## Test plan
- mult a=7, b=0xFFFFFFFD (−3) -> `done` 33 cycles after E0; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB; `div_zero`=0.
- mult a=b=0x80000000 -> `hi`=0x40000000, `lo`=0x00000000; mult 0xFFFFFFFF×0xFFFFFFFF -> `hi`=0, `lo`=1.
- div a=0xFFFFFFF9 (−7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- div a=100, b=7 -> `lo`=14, `hi`=2.
- div 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- Divide-by-zero: preload `hi`=0x11, `lo`=0x22 from a prior mult; div b=0 -> `done`=`div_zero`=1 exactly one cycle after E0; `busy` stays 0; `hi`/`lo` remain 0x11/0x22.
- Protocol: `start` held high during a mult -> no restart, single `done`. New div issued in the `done` cycle -> accepted, its `done` arrives 33 cycles later. `reset` at iteration 10 -> `busy`=0, `hi`=`lo`=0 next cycle, no `done` pulse thereafter.
